// File: rtl/div_seq_pkg.sv
// Shared definitions for the iterative EX-stage divider: FSM encodings,
// iteration count and the decode bits carried from ID to EX.
package div_seq_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  localparam int DIV_ITER = 32;

  // Divider decode bits as they travel on the ID->EX bus
  typedef struct packed {
    logic div_signed;
    logic div_mod;
  } id2ex_div_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor magnitude and keep the difference when it does not go negative.
module div_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem,
  input  logic              dividend_msb,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_nxt,
  output logic              q_bit
);

  logic [DATA_W:0] shifted;
  logic [DATA_W:0] trial;

  // rem < divisor holds on entry, so the difference always fits in DATA_W+1
  // signed bits and its top bit is a true sign.
  assign shifted = {rem, dividend_msb};
  assign trial   = shifted - {1'b0, divisor};
  assign q_bit   = ~trial[DATA_W];
  assign rem_nxt = q_bit ? trial[DATA_W-1:0] : shifted[DATA_W-1:0];

endmodule

// File: rtl/div_seq.sv
// Iterative 32-bit divider for div.w/mod.w/div.wu/mod.wu: one quotient bit per
// cycle, early finish on divide-by-zero, cancellable by flush.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              div_start_i,
  input  logic              div_signed_i,
  input  logic              div_mod_i,
  input  logic [DATA_W-1:0] div_opd1_i,
  input  logic [DATA_W-1:0] div_opd2_i,
  input  logic              flush_i,
  output logic              div_busy_o,
  output logic              div_end_o,
  output logic [DATA_W-1:0] div_result_o
);

  div_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] rem_q, quo_q, dvs_q, result_q;
  logic              signed_q, mod_q, sign1_q, sign2_q;

  logic [DATA_W-1:0] rem_nxt, quo_nxt, mag1, mag2, result_fin;
  logic              q_bit, last_step, div_zero;

  function automatic logic [DATA_W-1:0] neg_if(input logic [DATA_W-1:0] v,
                                               input logic              c);
    return c ? -v : v;
  endfunction

  assign mag1      = neg_if(div_opd1_i, div_signed_i & div_opd1_i[DATA_W-1]);
  assign mag2      = neg_if(div_opd2_i, div_signed_i & div_opd2_i[DATA_W-1]);
  assign div_zero  = (div_opd2_i == '0);
  assign last_step = (cnt_q == CNT_W'(1));

  div_step #(.DATA_W(DATA_W)) u_step (
    .rem         (rem_q),
    .dividend_msb(quo_q[DATA_W-1]),
    .divisor     (dvs_q),
    .rem_nxt     (rem_nxt),
    .q_bit       (q_bit)
  );

  assign quo_nxt = {quo_q[DATA_W-2:0], q_bit};

  // Remainder follows the dividend sign; quotient negates on differing signs
  assign result_fin = mod_q ? neg_if(rem_nxt, signed_q & sign1_q)
                            : neg_if(quo_nxt, signed_q & (sign1_q ^ sign2_q));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= DIV_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    div_busy_o = 1'b0;
    div_end_o  = 1'b0;
    case (state_q)
      DIV_IDLE: if (div_start_i) state_d = div_zero ? DIV_DONE : DIV_CALC;
      DIV_CALC: begin
        div_busy_o = 1'b1;
        if (last_step) state_d = DIV_DONE;
      end
      DIV_DONE: begin
        div_busy_o = 1'b1;
        div_end_o  = 1'b1;
        state_d    = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase
    if (flush_i) state_d = DIV_IDLE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      result_q <= '0;
      signed_q <= 1'b0;
      mod_q    <= 1'b0;
      sign1_q  <= 1'b0;
      sign2_q  <= 1'b0;
    end else if (!flush_i) begin
      case (state_q)
        DIV_IDLE: if (div_start_i) begin
          signed_q <= div_signed_i;
          mod_q    <= div_mod_i;
          sign1_q  <= div_opd1_i[DATA_W-1];
          sign2_q  <= div_opd2_i[DATA_W-1];
          quo_q    <= mag1;
          dvs_q    <= mag2;
          rem_q    <= '0;
          cnt_q    <= CNT_W'(DATA_W);
          // Divide-by-zero: all-ones quotient, dividend returned untouched
          if (div_zero) result_q <= div_mod_i ? div_opd1_i : '1;
        end
        DIV_CALC: begin
          rem_q <= rem_nxt;
          quo_q <= quo_nxt;
          cnt_q <= cnt_q - CNT_W'(1);
          if (last_step) result_q <= result_fin;
        end
        default: ;
      endcase
    end
  end

  assign div_result_o = result_q;

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: vector table for arithmetic/latency plus
// hand-written flush, reset and handshake sequences.
module tb_div_seq;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic        m;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, sgn = 1'b0, md = 1'b0, flush = 1'b0;
  logic [31:0] opd1 = '0, opd2 = '0;
  logic        div_busy_o, div_end_o;
  logic [31:0] div_result_o;

  int n_pass = 0;
  int n_total = 0;
  int end_cnt = 0;

  div_seq #(.DATA_W(32), .CNT_W(6)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .div_start_i (start),
    .div_signed_i(sgn),
    .div_mod_i   (md),
    .div_opd1_i  (opd1),
    .div_opd2_i  (opd2),
    .flush_i     (flush),
    .div_busy_o  (div_busy_o),
    .div_end_o   (div_end_o),
    .div_result_o(div_result_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (div_end_o) end_cnt++;

  function automatic vec_t mk(logic [31:0] a, logic [31:0] b, logic s, logic m,
                              logic [31:0] exp, int lat);
    vec_t v;
    v.a = a; v.b = b; v.s = s; v.m = m; v.exp = exp; v.lat = lat;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
  endtask

  // Issue one request; lat = negedges after the first post-accept sample
  // until div_end_o is seen (40 = never seen).
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic m, output int lat, output logic busy0);
    @(negedge clk);
    opd1 = a; opd2 = b; sgn = s; md = m; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy0 = div_busy_o;
    lat = 0;
    while (!div_end_o && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  vec_t vecs[$];
  int   lat, ec;
  logic busy0;

  initial begin
    vecs.push_back(mk(32'd100,      32'd7,          1'b0, 1'b0, 32'd14,       32));
    vecs.push_back(mk(32'd100,      32'd7,          1'b0, 1'b1, 32'd2,        32));
    vecs.push_back(mk(32'hFFFFFFF9, 32'd2,          1'b1, 1'b0, 32'hFFFFFFFD, 32));
    vecs.push_back(mk(32'hFFFFFFF9, 32'd2,          1'b1, 1'b1, 32'hFFFFFFFF, 32));
    vecs.push_back(mk(32'd7,        32'hFFFFFFFE,   1'b1, 1'b0, 32'hFFFFFFFD, 32));
    vecs.push_back(mk(32'd7,        32'hFFFFFFFE,   1'b1, 1'b1, 32'd1,        32));
    vecs.push_back(mk(32'h80000000, 32'hFFFFFFFF,   1'b1, 1'b0, 32'h80000000, 32));
    vecs.push_back(mk(32'h80000000, 32'hFFFFFFFF,   1'b1, 1'b1, 32'd0,        32));
    vecs.push_back(mk(32'hFFFFFFFF, 32'd1,          1'b0, 1'b0, 32'hFFFFFFFF, 32));
    vecs.push_back(mk(32'hFFFFFFF9, 32'd2,          1'b0, 1'b0, 32'h7FFFFFFC, 32));
    vecs.push_back(mk(32'd5,        32'd0,          1'b1, 1'b0, 32'hFFFFFFFF, 0));
    vecs.push_back(mk(32'd5,        32'd0,          1'b0, 1'b0, 32'hFFFFFFFF, 0));
    vecs.push_back(mk(32'd5,        32'd0,          1'b1, 1'b1, 32'd5,        0));
    vecs.push_back(mk(32'd5,        32'd0,          1'b0, 1'b1, 32'd5,        0));
    vecs.push_back(mk(32'hFFFFFFFB, 32'd0,          1'b1, 1'b1, 32'hFFFFFFFB, 0));
    vecs.push_back(mk(32'd3,        32'd10,         1'b0, 1'b0, 32'd0,        32));
    vecs.push_back(mk(32'd3,        32'd10,         1'b0, 1'b1, 32'd3,        32));
    vecs.push_back(mk(32'hFFFFFFFD, 32'd10,         1'b1, 1'b1, 32'hFFFFFFFD, 32));

    // Reset state
    repeat (2) @(negedge clk);
    check("reset busy", {31'd0, div_busy_o}, 32'd0);
    check("reset end", {31'd0, div_end_o}, 32'd0);
    check("reset result", div_result_o, 32'd0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].m, lat, busy0);
      check($sformatf("v%0d latency", i), lat, vecs[i].lat);
      check($sformatf("v%0d result", i), div_result_o, vecs[i].exp);
      check($sformatf("v%0d busy", i), {31'd0, busy0}, 32'd1);
      @(negedge clk);
      check($sformatf("v%0d idle after", i), {30'd0, div_busy_o, div_end_o}, 32'd0);
    end

    // Flush at CALC cycle 10: no end pulse, result keeps the last value
    @(negedge clk);
    opd1 = 32'd1000; opd2 = 32'd3; sgn = 1'b0; md = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ec = end_cnt;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush busy", {31'd0, div_busy_o}, 32'd0);
    check("flush result held", div_result_o, 32'hFFFFFFFD);
    repeat (40) @(negedge clk);
    check("flush no end", end_cnt - ec, 32'd0);
    run_op(32'd9, 32'd3, 1'b0, 1'b0, lat, busy0);
    check("post-flush latency", lat, 32'd32);
    check("post-flush result", div_result_o, 32'd3);

    // Flush and start together: start dropped
    @(negedge clk);
    opd1 = 32'd8; opd2 = 32'd2; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush+start busy", {31'd0, div_busy_o}, 32'd0);
    repeat (3) @(negedge clk);
    check("flush+start result", div_result_o, 32'd3);

    // Flush in DONE: pulse still present, result kept
    run_op(32'd5, 32'd0, 1'b0, 1'b0, lat, busy0);
    flush = 1'b1;
    check("done-flush end", {31'd0, div_end_o}, 32'd1);
    @(negedge clk);
    flush = 1'b0;
    check("done-flush idle", {30'd0, div_busy_o, div_end_o}, 32'd0);
    check("done-flush result", div_result_o, 32'hFFFFFFFF);

    // Start while busy and start during DONE are both ignored
    @(negedge clk);
    opd1 = 32'd100; opd2 = 32'd7; sgn = 1'b0; md = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ec = end_cnt;
    repeat (4) @(negedge clk);
    opd1 = 32'd50; opd2 = 32'd5; md = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 5;
    while (!div_end_o && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("busy-start latency", lat, 32'd32);
    check("busy-start result", div_result_o, 32'd14);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("done-start ignored", {31'd0, div_busy_o}, 32'd0);
    repeat (40) @(negedge clk);
    check("single end pulse", end_cnt - ec, 32'd1);

    // Reset mid-CALC clears everything at once
    @(negedge clk);
    opd1 = 32'd1000; opd2 = 32'd3; md = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ec = end_cnt;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid-reset busy", {31'd0, div_busy_o}, 32'd0);
    check("mid-reset end", {31'd0, div_end_o}, 32'd0);
    check("mid-reset result", div_result_o, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("mid-reset no end", end_cnt - ec, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Iterative 32-bit integer divider with its sequencing FSM, instantiated inside the EX stage beside the ALU and multiplier.
- Executes div.w, mod.w, div.wu and mod.wu as a multi-cycle operation, one quotient bit per cycle.
- EX holds ctl_ex_over low until div_end_o pulses, using the same (~is_div | div_end) pattern as the multiply path.
- Supports flush cancellation and early completion on divide-by-zero.

Parameters:
- DATA_W, 32, operand/result width.
- CNT_W, 6, iteration counter width (must hold DATA_W).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous reset, active-high.
- div_start_i  in  1  request; sampled only in IDLE.
- div_signed_i  in  1  1 = signed (div.w/mod.w), 0 = unsigned.
- div_mod_i  in  1  1 = return remainder, 0 = return quotient.
- div_opd1_i  in  DATA_W  dividend (rj).
- div_opd2_i  in  DATA_W  divisor (rk).
- flush_i  in  1  cancel current operation.
- div_busy_o  out  1  high in CALC and DONE.
- div_end_o  out  1  one-cycle completion pulse.
- div_result_o  out  DATA_W  selected result; valid when div_end_o=1; held until next accepted start.

Behaviour:
- Reset: async on rst_i. State goes to IDLE; counter, remainder, quotient and the latched sign/mod flags go to 0. div_busy_o=0, div_end_o=0, div_result_o=0. Reset mid-operation discards the operation with no end pulse.
- States: IDLE, CALC, DONE (encodings from common.vh).
- IDLE:
  - On div_start_i=1 and flush_i=0, latch div_signed_i, div_mod_i, opd1 sign, opd2 sign and operand magnitudes. Magnitude is the two's-complement abs if signed, raw otherwise.
  - Divisor == 0: go to DONE.
  - Otherwise: clear the partial remainder, counter=DATA_W, go to CALC.
- CALC, one restoring step per cycle (via div_step):
  - Shift {rem, dividend} left by 1.
  - Trial-subtract the divisor magnitude over DATA_W+1 bits.
  - If non-negative, keep the difference and shift in quotient bit 1; else shift in 0.
  - Decrement counter; on the step where counter is 1, go to DONE.
- DONE:
  - div_end_o=1 for exactly this cycle.
  - div_result_o registered with the sign-corrected value.
  - Next state IDLE unconditionally; div_start_i is ignored in DONE.
- Latency:
  - Start accepted at edge N → div_end_o high in cycle N+33 (32 CALC cycles + DONE).
  - Divide-by-zero → div_end_o high in cycle N+1.
- Sign rules (signed only):
  - Quotient is negated when opd1 sign != opd2 sign.
  - Remainder takes the sign of the dividend.
  - Unsigned results are never negated.
- Boundary cases:
  - Divide by zero: quotient = all-ones, remainder = dividend unchanged, in both signed and unsigned mode.
  - Signed overflow 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0. This falls out of magnitude arithmetic; no special case.
  - Dividend magnitude < divisor magnitude: quotient 0, remainder = dividend.
- Handshake:
  - div_start_i while busy is ignored; no queueing.
  - The requester must consume the result in the div_end_o cycle. EX advances on ctl_ex_over, so the same instruction does not re-request.
- Flush:
  - flush_i=1 in any state → IDLE at the next edge, no div_end_o, div_result_o unchanged.
  - Flush and start in the same cycle: flush wins and the start is dropped.
  - Flush during the DONE cycle: div_end_o still pulses in that cycle; EX masks it with its own valid.
- Counter arithmetic is unsigned over CNT_W; wrap past 0 is unreachable.

Decomposition:
- common.vh:
  - DivStateW, DIV_IDLE/DIV_CALC/DIV_DONE encodings.
  - DivIter (=32).
  - ID2EX bus fields for the div_signed/div_mod decode bits.
- Sub-module div_step (combinational):
  - Inputs: partial remainder, dividend MSB, divisor magnitude.
  - Outputs: next remainder, quotient bit.
  - Keeps the FSM file focused on sequencing and sign correction.

Test Plan:
- Unsigned 100 / 7, div_mod_i=0 → div_end_o at N+33, result 14; repeat with div_mod_i=1 → 2; div_busy_o high N+1..N+33.
- Signed 0xFFFFFFF9 (-7) / 2 → quotient 0xFFFFFFFD; mod → 0xFFFFFFFF. Also 7 / -2 → quotient 0xFFFFFFFD; mod → 1.
- Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, mod 0. Unsigned 0xFFFFFFFF / 1 → 0xFFFFFFFF.
- 5 / 0 (signed and unsigned) → div_end_o at N+1, quotient 0xFFFFFFFF, mod 5.
- Start 1000 / 3, flush_i at CALC cycle 10 → no div_end_o, busy low next cycle. New start 9 / 3 accepted → 3 at +33.
- Assert rst_i mid-CALC → all outputs 0 immediately. A second start pulsed while busy is ignored, so exactly one div_end_o occurs.
